ddr3_full_seq: RTL and testbench

Sequencer for the DDR3 FIFO-full flag seen by the command handler. It replaces the fixed delay on DDR3_FULL and adds three controls: a programmable assertion delay, short-glitch rejection, and a release hold while a data header is being built. The hold keeps DATA_PKTS frozen until the header is complete. It sits between the DDR3 controller's full flag and the CommandHandler, and exports a sticky timeout error and an event count for the register map.

---
 rtl/ddr3_full_seq_pkg.sv | 20 ++
 rtl/ddr3_full_seq.sv | 147 ++++++++++++++
 tb/tb_ddr3_full_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_full_seq_pkg.sv
// Shared state encodings and default timing for the DDR3 full-flag sequencer,
// so the register map and debug logic decode state_dbg the same way.
package ddr3_full_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_FULL     = 3'd2,
        S_WAIT_HDR = 3'd3,
        S_DROP     = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam int DEF_ASSERT_DLY   = 8;
    localparam int DEF_DEASSERT_DLY = 2;
    localparam int DEF_HDR_TIMEOUT  = 1023;
    localparam int DEF_MIN_OFF      = 4;
    localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/ddr3_full_seq.sv
// Sequences the raw DDR3 full flag toward the CommandHandler: delayed assertion,
// glitch rejection, and a release hold while a data header is being built.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | not full, waiting for full_in
// ARM        | full_in seen, counting down the assertion delay
// FULL       | full_out asserted
// WAIT_HDR   | full_in dropped mid-header, release held, timer counts up
// DROP       | counting down the release delay, full_out still high
// COOLDOWN   | full_out low for MIN_OFF clocks, full_in ignored
module ddr3_full_seq
    import ddr3_full_seq_pkg::*;
#(
    parameter int ASSERT_DLY   = DEF_ASSERT_DLY,
    parameter int DEASSERT_DLY = DEF_DEASSERT_DLY,
    parameter int HDR_TIMEOUT  = DEF_HDR_TIMEOUT,
    parameter int MIN_OFF      = DEF_MIN_OFF,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             full_in,
    input  logic             hdr_busy,
    input  logic             hdr_done,
    input  logic             clr_err,
    output logic             full_out,
    output logic             pkts_freeze,
    output logic             timeout_err,
    output logic [CNT_W-1:0] full_events,
    output logic [2:0]       state_dbg
);

    localparam logic [CNT_W-1:0] ASSERT_LD    = CNT_W'(ASSERT_DLY - 1);
    localparam logic [CNT_W-1:0] DEASSERT_LD  = CNT_W'(DEASSERT_DLY - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LD   = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(HDR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             cnt_inc;
    logic             err_set;

    // One shared timer: down-counter everywhere except WAIT_HDR, where it counts up.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        cnt_inc   = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (full_in) begin
                    state_nxt = S_ARM;
                    timer_nxt = ASSERT_LD;
                end
            end
            S_ARM: begin
                if (!full_in) begin
                    state_nxt = S_IDLE;
                end else if (timer == '0) begin
                    state_nxt = S_FULL;
                    cnt_inc   = 1'b1;
                end else begin
                    timer_nxt = timer - ONE;
                end
            end
            S_FULL: begin
                if (!full_in) begin
                    if (hdr_busy) begin
                        state_nxt = S_WAIT_HDR;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = S_DROP;
                        timer_nxt = DEASSERT_LD;
                    end
                end
            end
            S_WAIT_HDR: begin
                if (full_in) begin
                    state_nxt = S_FULL;
                end else if (hdr_done) begin
                    state_nxt = S_DROP;
                    timer_nxt = DEASSERT_LD;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nxt = S_COOLDOWN;
                    timer_nxt = MIN_OFF_LD;
                    err_set   = 1'b1;
                end else begin
                    timer_nxt = timer + ONE;
                end
            end
            S_DROP: begin
                if (full_in) begin
                    state_nxt = S_FULL;
                end else if (timer == '0) begin
                    state_nxt = S_COOLDOWN;
                    timer_nxt = MIN_OFF_LD;
                end else begin
                    timer_nxt = timer - ONE;
                end
            end
            S_COOLDOWN: begin
                if (timer == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer - ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state so they always match its decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            full_out    <= 1'b0;
            pkts_freeze <= 1'b0;
            timeout_err <= 1'b0;
            full_events <= '0;
            state_dbg   <= 3'd0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            full_out    <= (state_nxt == S_FULL) || (state_nxt == S_WAIT_HDR) ||
                           (state_nxt == S_DROP);
            pkts_freeze <= (state_nxt == S_WAIT_HDR);
            state_dbg   <= state_nxt;
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (cnt_inc && (full_events != '1)) begin
                full_events <= full_events + ONE;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_full_seq.sv
// Bench for ddr3_full_seq: phase/age model checked every cycle, directed
// scenarios with literal checks, and a narrow-counter instance for saturation.
module tb_ddr3_full_seq;

    localparam int A_DLY = 8;
    localparam int D_DLY = 2;
    localparam int T_OUT = 1023;
    localparam int M_OFF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        full_in, hdr_busy, hdr_done, clr_err;
    logic        full_out, pkts_freeze, timeout_err;
    logic [15:0] full_events;
    logic [2:0]  state_dbg;

    logic        s_rst_n = 1'b0;
    logic        s_full_in;
    logic        s_full_out, s_pkts_freeze, s_timeout_err;
    logic [3:0]  s_full_events;
    logic [2:0]  s_state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr3_full_seq dut (
        .clk(clk), .rst_n(rst_n), .full_in(full_in), .hdr_busy(hdr_busy),
        .hdr_done(hdr_done), .clr_err(clr_err), .full_out(full_out),
        .pkts_freeze(pkts_freeze), .timeout_err(timeout_err),
        .full_events(full_events), .state_dbg(state_dbg)
    );

    ddr3_full_seq #(
        .ASSERT_DLY(1), .DEASSERT_DLY(1), .HDR_TIMEOUT(10), .MIN_OFF(1), .CNT_W(4)
    ) u_sat (
        .clk(clk), .rst_n(s_rst_n), .full_in(s_full_in), .hdr_busy(1'b0),
        .hdr_done(1'b0), .clr_err(1'b0), .full_out(s_full_out),
        .pkts_freeze(s_pkts_freeze), .timeout_err(s_timeout_err),
        .full_events(s_full_events), .state_dbg(s_state_dbg)
    );

    // Model: phase number plus clocks spent in the phase; exits compare age to the delays.
    int m_ph, m_age, m_events, nph;
    bit m_err, set_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_age = 0; m_events = 0; m_err = 0;
        end else begin
            nph = m_ph;
            set_err = 0;
            case (m_ph)
                0: if (full_in) nph = 1;
                1: if (!full_in) nph = 0;
                   else if (m_age == A_DLY - 1) begin
                       nph = 2;
                       if (m_events < 65535) m_events++;
                   end
                2: if (!full_in) nph = hdr_busy ? 3 : 4;
                3: if (full_in) nph = 2;
                   else if (hdr_done) nph = 4;
                   else if (m_age == T_OUT - 1) begin nph = 5; set_err = 1; end
                4: if (full_in) nph = 2;
                   else if (m_age == D_DLY - 1) nph = 5;
                5: if (m_age == M_OFF - 1) nph = 0;
                default: nph = 0;
            endcase
            if (set_err) m_err = 1;
            else if (clr_err) m_err = 0;
            m_age = (nph == m_ph) ? m_age + 1 : 0;
            m_ph = nph;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (full_out !== (m_ph >= 2 && m_ph <= 4) || pkts_freeze !== (m_ph == 3) ||
                timeout_err !== m_err || full_events !== 16'(m_events) ||
                state_dbg !== 3'(m_ph)) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got full=%b frz=%b err=%b ev=%0d st=%0d, want full=%b frz=%b err=%b ev=%0d st=%0d",
                         $time, full_out, pkts_freeze, timeout_err, full_events, state_dbg,
                         (m_ph >= 2 && m_ph <= 4), (m_ph == 3), m_err, m_events, m_ph);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        full_in = 0; hdr_busy = 0; hdr_done = 0; clr_err = 0; s_full_in = 0;
        tick(3);
        rst_n = 1; s_rst_n = 1;
        check("rst_full_out", full_out, 0);
        check("rst_freeze", pkts_freeze, 0);
        check("rst_err", timeout_err, 0);
        check("rst_events", full_events, 0);
        check("rst_state", state_dbg, 0);

        // basic assert: full_in high for 20 edges
        full_in = 1;
        tick(8);
        check("basic_before_edge8", full_out, 0);
        tick(1);
        check("basic_edge8", full_out, 1);
        check("basic_state_full", state_dbg, 2);
        check("basic_events", full_events, 1);
        check("model_events_pin", m_events, 1);
        hdr_done = 1;
        tick(1);
        hdr_done = 0;
        check("hdr_done_ignored", state_dbg, 2);
        tick(10);
        full_in = 0;
        tick(2);
        check("basic_drop_hold", full_out, 1);
        check("basic_drop_state", state_dbg, 4);
        tick(1);
        check("basic_fall", full_out, 0);
        check("basic_cooldown", state_dbg, 5);
        tick(4);
        check("basic_idle", state_dbg, 0);
        check("model_phase_pin", m_ph, 0);

        // glitch of 5 clocks
        full_in = 1;
        tick(5);
        full_in = 0;
        tick(1);
        check("glitch_state", state_dbg, 0);
        check("glitch_full_out", full_out, 0);
        check("glitch_events", full_events, 1);

        // header hold for 40 clocks
        hdr_busy = 1; full_in = 1;
        tick(9);
        check("hold_events", full_events, 2);
        full_in = 0;
        tick(1);
        check("hold_state", state_dbg, 3);
        check("hold_freeze", pkts_freeze, 1);
        tick(39);
        check("hold_40_freeze", pkts_freeze, 1);
        check("hold_40_full", full_out, 1);
        hdr_done = 1;
        tick(1);
        hdr_done = 0; hdr_busy = 0;
        check("hold_freeze_fall", pkts_freeze, 0);
        check("hold_full_still", full_out, 1);
        tick(1);
        check("hold_full_still2", full_out, 1);
        tick(1);
        check("hold_full_fall", full_out, 0);
        tick(4);
        check("hold_idle", state_dbg, 0);

        // timeout with a clr_err on the setting edge
        hdr_busy = 1; full_in = 1;
        tick(9);
        full_in = 0;
        tick(1);
        tick(1022);
        check("timeout_pre_state", state_dbg, 3);
        check("timeout_pre_err", timeout_err, 0);
        clr_err = 1;
        tick(1);
        clr_err = 0;
        check("timeout_set_wins", timeout_err, 1);
        check("timeout_full_out", full_out, 0);
        check("timeout_state", state_dbg, 5);
        hdr_busy = 0;
        tick(5);
        check("timeout_sticky", timeout_err, 1);
        clr_err = 1;
        tick(1);
        clr_err = 0;
        check("timeout_cleared", timeout_err, 0);

        // re-rise from WAIT_HDR and DROP, then re-assert through COOLDOWN
        hdr_busy = 1; full_in = 1;
        tick(9);
        check("rerise_events", full_events, 4);
        full_in = 0;
        tick(4);
        check("rerise_wait", state_dbg, 3);
        full_in = 1;
        tick(1);
        check("rerise_from_wait", state_dbg, 2);
        check("rerise_wait_full", full_out, 1);
        hdr_busy = 0; full_in = 0;
        tick(1);
        check("rerise_drop", state_dbg, 4);
        full_in = 1;
        tick(1);
        check("rerise_from_drop", state_dbg, 2);
        check("rerise_no_count", full_events, 4);
        full_in = 0;
        tick(3);
        check("cool_fell", full_out, 0);
        full_in = 1;
        tick(12);
        check("cool_not_yet", full_out, 0);
        tick(1);
        check("cool_reassert_13", full_out, 1);
        check("cool_events", full_events, 5);
        full_in = 0;
        tick(8);

        // narrow counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            s_full_in = 1;
            tick(2);
            check("sat_full_out", s_full_out, 1);
            check("sat_events", s_full_events, (i + 1 > 15) ? 15 : i + 1);
            s_full_in = 0;
            tick(3);
            check("sat_idle", s_state_dbg, 0);
        end
        s_full_in = 1;
        tick(2);
        check("sat_final_full", s_state_dbg, 2);
        check("sat_final_events", s_full_events, 15);
        #3;
        s_rst_n = 0;
        #1;
        check("async_full_out", s_full_out, 0);
        check("async_events", s_full_events, 0);
        check("async_state", s_state_dbg, 0);
        check("async_freeze", s_pkts_freeze, 0);
        check("async_err", s_timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
